vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 99 +++++++++
 tb/tb_vga_timing.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: pixel-enable divider, h/v counters, frame tick,
// and a one-pixel registered output stage that keeps colour and syncs aligned.
module vga_timing #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       active,
  output logic       tick,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] div_cnt;
  logic       pe;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       hsync_raw, vsync_raw;

  // With CLK_DIV=1 DIV_LAST is 0, so the divider sits at 0 and pe stays high.
  assign pe = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   div_cnt <= '0;
    else if (pe) div_cnt <= '0;
    else         div_cnt <= div_cnt + 4'd1;
  end

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pe) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign xpos      = h_cnt;
  assign ypos      = v_cnt;
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vsync_raw = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Tick marks entry into vertical blanking so gameplay state only moves off-screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   tick <= 1'b0;
    else if (pe) tick <= (h_nxt == 10'd0) && (v_nxt == V_ACT);
  end

  // Colour and syncs pass through the same register so they stay pixel-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
      vga_rgb   <= 3'b000;
    end else if (pe) begin
      vga_hsync <= hsync_raw ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= vsync_raw ? SYNC_POL : ~SYNC_POL;
      vga_rgb   <= active ? rgb_in : 3'b000;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two shrunken-raster instances (CLK_DIV=2 active-low sync,
// CLK_DIV=1 active-high sync) checked against a pixel-index arithmetic model.
module tb_vga_timing;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIV0 = 2, DIV1 = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rgb0 = 3'b000, rgb1 = 3'b000;
  logic [9:0] x0, y0, x1, y1;
  logic       act0, tick0, hs0, vs0, act1, tick1, hs1, vs1;
  logic [2:0] rgbo0, rgbo1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_timing #(.CLK_DIV(DIV0), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .rgb_in(rgb0), .xpos(x0), .ypos(y0), .active(act0),
    .tick(tick0), .vga_hsync(hs0), .vga_vsync(vs0), .vga_rgb(rgbo0));

  vga_timing #(.CLK_DIV(DIV1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .rgb_in(rgb1), .xpos(x1), .ypos(y1), .active(act1),
    .tick(tick1), .vga_hsync(hs1), .vga_vsync(vs1), .vga_rgb(rgbo1));

  // ---------------- reference model: pixel index since reset ----------------
  int         clks[2];
  int         pix[2];
  logic       e_hs[2], e_vs[2], e_tick[2];
  logic [2:0] e_rgb[2];

  function automatic int div_of(input int i);  return (i == 0) ? DIV0 : DIV1; endfunction
  function automatic logic pol_of(input int i); return (i == 0) ? 1'b0 : 1'b1; endfunction
  function automatic int f_h(input int p); return p % HT; endfunction
  function automatic int f_v(input int p); return (p / HT) % VT; endfunction
  function automatic logic f_act(input int p); return (f_h(p) < HA) && (f_v(p) < VA); endfunction
  function automatic logic f_hs(input int p); return (f_h(p) >= HA + HF) && (f_h(p) < HA + HF + HS); endfunction
  function automatic logic f_vs(input int p); return (f_v(p) >= VA + VF) && (f_v(p) < VA + VF + VS); endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        clks[i]   <= 0;
        pix[i]    <= 0;
        e_hs[i]   <= ~pol_of(i);
        e_vs[i]   <= ~pol_of(i);
        e_tick[i] <= 1'b0;
        e_rgb[i]  <= 3'b000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        clks[i] <= clks[i] + 1;
        if ((clks[i] + 1) % div_of(i) == 0) begin
          pix[i]    <= pix[i] + 1;
          e_hs[i]   <= f_hs(pix[i]) ? pol_of(i) : ~pol_of(i);
          e_vs[i]   <= f_vs(pix[i]) ? pol_of(i) : ~pol_of(i);
          e_rgb[i]  <= f_act(pix[i]) ? ((i == 0) ? rgb0 : rgb1) : 3'b000;
          e_tick[i] <= (f_h(pix[i] + 1) == 0) && (f_v(pix[i] + 1) == VA);
        end
      end
    end
  end

  // mode 0: random per clock, 1: single marker pixel at (10,5), 2: constant white
  task automatic drive_rgb(input int mode);
    case (mode)
      0: begin rgb0 = 3'($urandom); rgb1 = 3'($urandom); end
      1: begin rgb0 = (f_h(pix[0]) == 10 && f_v(pix[0]) == 5) ? 3'b101 : 3'b000; rgb1 = 3'b000; end
      default: begin rgb0 = 3'b111; rgb1 = 3'b111; end
    endcase
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({x0, y0, tick0, rgbo0, hs0, vs0} !== {10'd0, 10'd0, 1'b0, 3'b000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_hold dut0: x=%0d y=%0d tick=%b rgb=%b hs=%b vs=%b, want 0 0 0 000 1 1",
               x0, y0, tick0, rgbo0, hs0, vs0);
    end
    n_cmp++;
    if ({x1, tick1, hs1, vs1} !== {10'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_hold dut1: x=%0d tick=%b hs=%b vs=%b, want 0 0 0 0", x1, tick1, hs1, vs1);
    end
    reset = 1'b0;
    // Run with random colour into line 1, then reset mid-line at h=10.
    for (int k = 0; k < 4 * HT * DIV0 && pix[0] != HT + 10; k++) begin
      @(negedge clk);
      drive_rgb(0);
    end
    n_cmp++;
    if (pix[0] != HT + 10) begin
      n_bad++;
      $display("FAIL reset_reach: model pixel %0d, want %0d", pix[0], HT + 10);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({x0, y0, tick0, rgbo0, hs0, vs0} !== {10'd0, 10'd0, 1'b0, 3'b000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_async dut0: x=%0d y=%0d tick=%b rgb=%b hs=%b vs=%b, want 0 0 0 000 1 1",
               x0, y0, tick0, rgbo0, hs0, vs0);
    end
    n_cmp++;
    if ({x1, y1, rgbo1, hs1, vs1} !== {10'd0, 10'd0, 3'b000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async dut1: x=%0d y=%0d rgb=%b hs=%b vs=%b, want 0 0 000 0 0",
               x1, y1, rgbo1, hs1, vs1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (x0 !== 10'd0 || x1 !== 10'd1) begin
      n_bad++;
      $display("FAIL reset_first_clk: x0=%0d x1=%0d, want 0 1", x0, x1);
    end
    @(negedge clk);
    n_cmp++;
    if (x0 !== 10'd1 || x1 !== 10'd2) begin
      n_bad++;
      $display("FAIL reset_second_clk: x0=%0d x1=%0d, want 1 2", x0, x1);
    end
  endtask

  task automatic test_random;
    logic [26:0] got, exp;
    for (int k = 0; k < 2 * HT * VT * DIV0; k++) begin
      @(negedge clk);
      got = {x0, y0, act0, tick0, hs0, vs0, rgbo0};
      exp = {10'(f_h(pix[0])), 10'(f_v(pix[0])), f_act(pix[0]), e_tick[0], e_hs[0], e_vs[0], e_rgb[0]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random dut0 clk=%0d: got %h want %h", k, got, exp);
      end
      got = {x1, y1, act1, tick1, hs1, vs1, rgbo1};
      exp = {10'(f_h(pix[1])), 10'(f_v(pix[1])), f_act(pix[1]), e_tick[1], e_hs[1], e_vs[1], e_rgb[1]};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random dut1 clk=%0d: got %h want %h", k, got, exp);
      end
      drive_rgb(0);
    end
  endtask

  task automatic test_line_timing;
    logic prev[2], cur[2];
    int   t_on[2], n_on[2];
    for (int i = 0; i < 2; i++) begin n_on[i] = 0; t_on[i] = 0; end
    @(negedge clk);
    prev[0] = hs0; prev[1] = hs1;
    for (int k = 1; k <= 4 * HT * DIV0; k++) begin
      @(negedge clk);
      cur[0] = hs0; cur[1] = hs1;
      for (int i = 0; i < 2; i++) begin
        if (prev[i] !== pol_of(i) && cur[i] === pol_of(i)) begin
          n_cmp++;
          if (((i == 0) ? x0 : x1) !== 10'(HA + HF + 1)) begin
            n_bad++;
            $display("FAIL hsync_start dut%0d: x=%0d, want %0d", i, (i == 0) ? x0 : x1, HA + HF + 1);
          end
          if (n_on[i] > 0) begin
            n_cmp++;
            if (k - t_on[i] != HT * div_of(i)) begin
              n_bad++;
              $display("FAIL hsync_period dut%0d: %0d clks, want %0d", i, k - t_on[i], HT * div_of(i));
            end
          end
          n_on[i]++;
          t_on[i] = k;
        end else if (prev[i] === pol_of(i) && cur[i] !== pol_of(i) && n_on[i] > 0) begin
          n_cmp++;
          if (k - t_on[i] != HS * div_of(i)) begin
            n_bad++;
            $display("FAIL hsync_width dut%0d: %0d clks, want %0d", i, k - t_on[i], HS * div_of(i));
          end
        end
        prev[i] = cur[i];
      end
      drive_rgb(0);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (n_on[i] < 3) begin
        n_bad++;
        $display("FAIL hsync_timeout dut%0d: %0d pulses, want at least 3", i, n_on[i]);
      end
    end
  endtask

  task automatic test_frame_tick;
    logic pv[2], cv[2], pt[2], ct[2];
    int   tv[2], nv[2], tt[2], nt[2], act_clks;
    for (int i = 0; i < 2; i++) begin nv[i] = 0; nt[i] = 0; tv[i] = 0; tt[i] = 0; end
    act_clks = 0;
    @(negedge clk);
    pv[0] = vs0; pv[1] = vs1; pt[0] = tick0; pt[1] = tick1;
    for (int k = 1; k <= 3 * HT * VT * DIV0 + 4 * HT * DIV0; k++) begin
      @(negedge clk);
      cv[0] = vs0; cv[1] = vs1; ct[0] = tick0; ct[1] = tick1;
      if (act0 === 1'b1) act_clks++;
      for (int i = 0; i < 2; i++) begin
        if (pv[i] !== pol_of(i) && cv[i] === pol_of(i)) begin
          n_cmp++;
          if ({(i == 0) ? x0 : x1, (i == 0) ? y0 : y1} !== {10'd1, 10'(VA + VF)}) begin
            n_bad++;
            $display("FAIL vsync_start dut%0d: x=%0d y=%0d, want 1 %0d", i,
                     (i == 0) ? x0 : x1, (i == 0) ? y0 : y1, VA + VF);
          end
          if (nv[i] > 0) begin
            n_cmp++;
            if (k - tv[i] != HT * VT * div_of(i)) begin
              n_bad++;
              $display("FAIL vsync_period dut%0d: %0d clks, want %0d", i, k - tv[i], HT * VT * div_of(i));
            end
            if (i == 0) begin
              n_cmp++;
              if (act_clks != HA * VA * DIV0) begin
                n_bad++;
                $display("FAIL active_count: %0d clks, want %0d", act_clks, HA * VA * DIV0);
              end
            end
          end
          if (i == 0) act_clks = 0;
          nv[i]++;
          tv[i] = k;
        end else if (pv[i] === pol_of(i) && cv[i] !== pol_of(i) && nv[i] > 0) begin
          n_cmp++;
          if (k - tv[i] != VS * HT * div_of(i)) begin
            n_bad++;
            $display("FAIL vsync_width dut%0d: %0d clks, want %0d", i, k - tv[i], VS * HT * div_of(i));
          end
        end
        if (pt[i] !== 1'b1 && ct[i] === 1'b1) begin
          n_cmp++;
          if ({(i == 0) ? x0 : x1, (i == 0) ? y0 : y1} !== {10'd0, 10'(VA)}) begin
            n_bad++;
            $display("FAIL tick_pos dut%0d: x=%0d y=%0d, want 0 %0d", i,
                     (i == 0) ? x0 : x1, (i == 0) ? y0 : y1, VA);
          end
          if (nt[i] > 0) begin
            n_cmp++;
            if (k - tt[i] != HT * VT * div_of(i)) begin
              n_bad++;
              $display("FAIL tick_period dut%0d: %0d clks, want %0d", i, k - tt[i], HT * VT * div_of(i));
            end
          end
          nt[i]++;
          tt[i] = k;
        end else if (pt[i] === 1'b1 && ct[i] !== 1'b1 && nt[i] > 0) begin
          n_cmp++;
          if (k - tt[i] != div_of(i)) begin
            n_bad++;
            $display("FAIL tick_width dut%0d: %0d clks, want %0d", i, k - tt[i], div_of(i));
          end
        end
        pv[i] = cv[i];
        pt[i] = ct[i];
      end
      drive_rgb(0);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (nv[i] < 3 || nt[i] < 3) begin
        n_bad++;
        $display("FAIL frame_timeout dut%0d: %0d vsyncs %0d ticks, want at least 3 each", i, nv[i], nt[i]);
      end
    end
  endtask

  task automatic test_colour_pipeline;
    int hits, bad0, bad1;
    logic first_ok;
    logic [2:0] want;
    hits = 0;
    first_ok = 1'b0;
    drive_rgb(1);
    for (int k = 0; k < HT * VT * DIV0 + 2 * HT * DIV0; k++) begin
      @(negedge clk);
      if (rgbo0 !== 3'b000) begin
        if (hits == 0 && rgbo0 === 3'b101 && x0 === 10'd11 && y0 === 10'd5) first_ok = 1'b1;
        hits++;
      end
      drive_rgb(1);
    end
    n_cmp++;
    if (hits != DIV0 || !first_ok) begin
      n_bad++;
      $display("FAIL marker_pixel: %0d nonzero clks (first at 11,5: %b), want %0d (1)", hits, first_ok, DIV0);
    end
    bad0 = 0;
    bad1 = 0;
    drive_rgb(2);
    for (int k = 0; k < HT * VT * DIV0 + 4; k++) begin
      @(negedge clk);
      want = f_act(pix[0] - 1) ? 3'b111 : 3'b000;
      if (rgbo0 !== want) bad0++;
      want = f_act(pix[1] - 1) ? 3'b111 : 3'b000;
      if (rgbo1 !== want) bad1++;
      drive_rgb(2);
    end
    n_cmp++;
    if (bad0 != 0) begin
      n_bad++;
      $display("FAIL blank_colour dut0: %0d wrong clks, want 0", bad0);
    end
    n_cmp++;
    if (bad1 != 0) begin
      n_bad++;
      $display("FAIL blank_colour dut1: %0d wrong clks, want 0", bad1);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_line_timing();
    test_frame_tick();
    test_colour_pipeline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
